mvmult_rs_engine: RTL and testbench

Parametrised fixed-point matrix-vector multiply engine for the estimator datapath: computes y = A·x for a ROWS×COLS signed coefficient matrix and a COLS-element signed vector. Each row result is rounded and saturated to W bits, with rounding and overflow policy selectable per run. It generalises the single-column, fixed-constant row loop to run-time coefficients, multi-column accumulation and per-row overflow flags. It sits between the state/measurement registers and the estimator update logic and uses the standard ap_start/ap_done block handshake.

---
 rtl/mvmult_rs_engine.sv | 213 +++++++++++++++++++++
 tb/tb_mvmult_rs_engine.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvmult_rs_engine.sv
// Fixed-point y = A*x engine: one MAC per cycle, per-row round (half-up or floor)
// and saturate/wrap to W bits, with per-row overflow flags and ap_start/ap_done handshake.
module mvmult_rs_engine #(
    parameter int W    = 21,
    parameter int FRAC = 14,
    parameter int ROWS = 3,
    parameter int COLS = 3
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     ap_start,
    output logic                     ap_done,
    output logic                     ap_idle,
    output logic                     ap_ready,
    input  logic [ROWS*COLS*W-1:0]   a_mat,
    input  logic [COLS*W-1:0]        x_vec,
    input  logic                     rnd_mode,
    input  logic                     sat_mode,
    output logic [ROWS*W-1:0]        y_vec,
    output logic                     y_ap_vld,
    output logic [ROWS-1:0]          ovf
);

    localparam int N     = ROWS * COLS;
    localparam int KW    = (N > 1) ? $clog2(N) : 1;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PW    = 2 * W;
    localparam int ACC_W = 2 * W + $clog2(COLS) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state_reg;
    logic [KW-1:0]      k_reg;
    logic [RW-1:0]      r_reg;
    logic [CW-1:0]      c_reg;
    logic               drain_reg;

    logic signed [W-1:0] a_in  [N];
    logic signed [W-1:0] x_in  [COLS];
    logic signed [W-1:0] a_reg [N];
    logic signed [W-1:0] x_reg [COLS];
    logic                rnd_reg;
    logic                sat_reg;

    logic signed [PW-1:0]    prod_reg;
    logic                    prod_vld_reg;
    logic                    prod_first_reg;
    logic                    prod_last_reg;
    logic [RW-1:0]           prod_row_reg;

    logic signed [ACC_W-1:0] acc_reg;
    logic                    acc_vld_reg;
    logic                    acc_last_reg;
    logic [RW-1:0]           acc_row_reg;

    logic signed [W-1:0]     y_reg [ROWS];
    logic [ROWS-1:0]         ovf_reg;

    logic                    accept;
    logic                    last_issue;
    logic                    last_col;

    assign accept     = ap_start && (state_reg == IDLE);
    assign last_col   = (c_reg == CW'(COLS - 1));
    assign last_issue = last_col && (r_reg == RW'(ROWS - 1));

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_a_unpack
            assign a_in[gi] = a_mat[gi*W +: W];
        end
        for (gi = 0; gi < COLS; gi++) begin : g_x_unpack
            assign x_in[gi] = x_vec[gi*W +: W];
        end
        for (gi = 0; gi < ROWS; gi++) begin : g_y_pack
            assign y_vec[gi*W +: W] = y_reg[gi];
        end
    endgenerate

    // Control: counters return to zero on the last issue so the operand index never leaves the array.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_reg <= IDLE;
            k_reg     <= '0;
            r_reg     <= '0;
            c_reg     <= '0;
            drain_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ap_start) begin
                        state_reg <= RUN;
                        k_reg     <= '0;
                        r_reg     <= '0;
                        c_reg     <= '0;
                    end
                end
                RUN: begin
                    if (last_issue) begin
                        state_reg <= DRAIN;
                        drain_reg <= 1'b0;
                        k_reg     <= '0;
                        r_reg     <= '0;
                        c_reg     <= '0;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                        if (last_col) begin
                            c_reg <= '0;
                            r_reg <= r_reg + 1'b1;
                        end else begin
                            c_reg <= c_reg + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    drain_reg <= 1'b1;
                    if (drain_reg) state_reg <= DONE;
                end
                DONE: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < N; i++) a_reg[i] <= '0;
            for (int i = 0; i < COLS; i++) x_reg[i] <= '0;
            rnd_reg <= 1'b0;
            sat_reg <= 1'b0;
        end else if (accept) begin
            a_reg   <= a_in;
            x_reg   <= x_in;
            rnd_reg <= rnd_mode;
            sat_reg <= sat_mode;
        end
    end

    logic signed [PW-1:0]    a_ext;
    logic signed [PW-1:0]    x_ext;
    logic signed [ACC_W-1:0] p_ext;

    assign a_ext = PW'(a_reg[k_reg]);
    assign x_ext = PW'(x_reg[c_reg]);
    assign p_ext = ACC_W'(prod_reg);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            prod_reg       <= '0;
            prod_vld_reg   <= 1'b0;
            prod_first_reg <= 1'b0;
            prod_last_reg  <= 1'b0;
            prod_row_reg   <= '0;
            acc_reg        <= '0;
            acc_vld_reg    <= 1'b0;
            acc_last_reg   <= 1'b0;
            acc_row_reg    <= '0;
        end else begin
            prod_vld_reg   <= (state_reg == RUN);
            prod_reg       <= a_ext * x_ext;
            prod_first_reg <= (c_reg == '0);
            prod_last_reg  <= last_col;
            prod_row_reg   <= r_reg;
            acc_vld_reg    <= prod_vld_reg;
            acc_last_reg   <= prod_last_reg;
            acc_row_reg    <= prod_row_reg;
            if (prod_vld_reg) begin
                acc_reg <= prod_first_reg ? p_ext : acc_reg + p_ext;
            end
        end
    end

    logic signed [ACC_W-1:0] rnd_add;
    logic signed [ACC_W-1:0] t_sum;
    logic signed [ACC_W-1:0] t_sh;
    logic [ACC_W-W:0]        t_hi;
    logic                    in_range;
    logic signed [W-1:0]     y_fin;

    always_comb begin
        rnd_add           = '0;
        rnd_add[FRAC-1]   = rnd_reg;
        t_sum             = acc_reg + rnd_add;
        t_sh              = t_sum >>> FRAC;
        // In range exactly when every bit from the W-bit sign upward agrees.
        t_hi              = t_sh[ACC_W-1:W-1];
        in_range          = (&t_hi) || (~|t_hi);
        y_fin             = t_sh[W-1:0];
        if (!in_range && sat_reg) begin
            y_fin = t_sh[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < ROWS; i++) y_reg[i] <= '0;
            ovf_reg <= '0;
        end else if (accept) begin
            ovf_reg <= '0;
        end else if (acc_vld_reg && acc_last_reg) begin
            y_reg[acc_row_reg] <= y_fin;
            if (!in_range) ovf_reg[acc_row_reg] <= 1'b1;
        end
    end

    assign ovf      = ovf_reg;
    assign ap_idle  = (state_reg == IDLE);
    assign ap_done  = (state_reg == DONE);
    assign ap_ready = ap_done;
    assign y_ap_vld = ap_done;

endmodule

// File: tb/tb_mvmult_rs_engine.sv
// Bench for mvmult_rs_engine: directed cases plus randomized runs scored against
// an integer reference model through an accept-time scoreboard.
module tb_mvmult_rs_engine;

    localparam int W    = 21;
    localparam int FRAC = 14;
    localparam int ROWS = 3;
    localparam int COLS = 3;
    localparam int N    = ROWS * COLS;
    localparam int RUN_CYC = ROWS * COLS + 4;
    localparam longint MAXV = (longint'(1) <<< (W - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (W - 1));

    logic                 ap_clk = 1'b0;
    logic                 ap_rst_n;
    logic                 ap_start;
    logic                 ap_done;
    logic                 ap_idle;
    logic                 ap_ready;
    logic [N*W-1:0]       a_mat;
    logic [COLS*W-1:0]    x_vec;
    logic                 rnd_mode;
    logic                 sat_mode;
    logic [ROWS*W-1:0]    y_vec;
    logic                 y_ap_vld;
    logic [ROWS-1:0]      ovf;

    always #5 ap_clk = ~ap_clk;

    mvmult_rs_engine #(.W(W), .FRAC(FRAC), .ROWS(ROWS), .COLS(COLS)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .ap_start (ap_start),
        .ap_done  (ap_done),
        .ap_idle  (ap_idle),
        .ap_ready (ap_ready),
        .a_mat    (a_mat),
        .x_vec    (x_vec),
        .rnd_mode (rnd_mode),
        .sat_mode (sat_mode),
        .y_vec    (y_vec),
        .y_ap_vld (y_ap_vld),
        .ovf      (ovf)
    );

    typedef struct {
        logic [ROWS*W-1:0] y;
        logic [ROWS-1:0]   o;
        int                due;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   next_ok  = 0;
    int   n_acc    = 0;

    // Reference: exact integer sum of products, then round/shift/clamp by plain arithmetic.
    function automatic void ref_model(input logic [N*W-1:0] a, input logic [COLS*W-1:0] x,
                                      input logic rnd, input logic sat,
                                      output logic [ROWS*W-1:0] y, output logic [ROWS-1:0] o);
        longint s;
        longint t;
        logic [63:0] tbits;
        logic signed [W-1:0] av;
        logic signed [W-1:0] xv;
        y = '0;
        o = '0;
        for (int r = 0; r < ROWS; r++) begin
            s = 0;
            for (int c = 0; c < COLS; c++) begin
                av = a[(r*COLS+c)*W +: W];
                xv = x[c*W +: W];
                s += longint'(av) * longint'(xv);
            end
            if (rnd) s += longint'(1) <<< (FRAC - 1);
            t = s >>> FRAC;
            if (t > MAXV || t < MINV) begin
                o[r] = 1'b1;
                if (sat) t = (t > MAXV) ? MAXV : MINV;
            end
            tbits = t;
            y[r*W +: W] = tbits[W-1:0];
        end
    endfunction

    // Scoreboard/monitor: accept model on rising edges, compare on falling edges.
    initial begin
        exp_t e;
        bit   exp_done;
        logic [3:0] exp_hs;
        logic [3:0] got_hs;
        forever begin
            @(posedge ap_clk);
            if (!ap_rst_n) begin
                sb_q.delete();
                next_ok = 0;
            end else if (ap_start && cyc >= next_ok) begin
                ref_model(a_mat, x_vec, rnd_mode, sat_mode, e.y, e.o);
                e.due   = cyc + RUN_CYC - 1;
                sb_q.push_back(e);
                next_ok = cyc + RUN_CYC;
                n_acc++;
            end
            cyc++;
            @(negedge ap_clk);
            if (!ap_rst_n) begin
                sb_q.delete();
                next_ok = 0;
            end else begin
                exp_done = (sb_q.size() > 0) && (sb_q[0].due == cyc);
                exp_hs   = {cyc >= next_ok, exp_done, exp_done, exp_done};
                got_hs   = {ap_idle, ap_done, ap_ready, y_ap_vld};
                n_checks++;
                if (got_hs !== exp_hs) begin
                    n_fail++;
                    $display("FAIL handshake cyc=%0d idle/done/ready/vld got=%b exp=%b", cyc, got_hs, exp_hs);
                end
                if (exp_done) begin
                    e = sb_q.pop_front();
                    n_checks++;
                    if (y_vec !== e.y) begin
                        n_fail++;
                        $display("FAIL sb_y cyc=%0d got=%h exp=%h", cyc, y_vec, e.y);
                    end
                    n_checks++;
                    if (ovf !== e.o) begin
                        n_fail++;
                        $display("FAIL sb_ovf cyc=%0d got=%b exp=%b", cyc, ovf, e.o);
                    end
                    $display("run done cyc=%0d y=%h ovf=%b", cyc, y_vec, ovf);
                end
            end
        end
    end

    task automatic chk(input string nm, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end else begin
            $display("check %s = %0d", nm, got);
        end
    endtask

    function automatic longint yrow(input int r);
        logic signed [W-1:0] v;
        v = y_vec[r*W +: W];
        return longint'(v);
    endfunction

    task automatic set_a(input int r, input int c, input int v);
        a_mat[(r*COLS+c)*W +: W] = W'(v);
    endtask

    task automatic set_x(input int c, input int v);
        x_vec[c*W +: W] = W'(v);
    endtask

    function automatic int rv();
        int v;
        case ($urandom_range(0, 4))
            0: v = int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
            1: v = int'($urandom_range(0, 64)) - 32;
            2: v = (1 << (W - 1)) - 1;
            3: v = -(1 << (W - 1));
            default: v = ($urandom_range(0, 1) == 1) ? 16384 : -16384;
        endcase
        return v;
    endfunction

    task automatic scramble();
        for (int i = 0; i < N; i++) set_a(i / COLS, i % COLS, rv());
        for (int c = 0; c < COLS; c++) set_x(c, rv());
    endtask

    task automatic wait_acc(input int target);
        bit ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge ap_clk);
            if (n_acc >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout got=%0d exp=%0d", n_acc, target);
        end
    endtask

    task automatic start_run(input logic rnd, input logic sat);
        int target;
        @(negedge ap_clk);
        #1;
        rnd_mode = rnd;
        sat_mode = sat;
        ap_start = 1'b1;
        target   = n_acc + 1;
        wait_acc(target);
        #1;
        ap_start = 1'b0;
        scramble();
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge ap_clk);
            if (ap_done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout got=0 exp=1");
        end
    endtask

    task automatic run_dir(input logic rnd, input logic sat);
        start_run(rnd, sat);
        wait_done();
    endtask

    task automatic wait_drained();
        for (int i = 0; i < 80 && sb_q.size() > 0; i++) @(negedge ap_clk);
        chk("scoreboard_drained", sb_q.size(), 0);
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge ap_clk);
            if (ap_done) cnt++;
        end
    endtask

    task automatic load_identity();
        a_mat = '0;
        for (int r = 0; r < ROWS; r++) set_a(r, r, 16384);
        set_x(0, 100); set_x(1, -200); set_x(2, 300);
    endtask

    initial begin
        int cnt;
        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        rnd_mode = 1'b0;
        sat_mode = 1'b0;
        a_mat    = '0;
        x_vec    = '0;
        repeat (2) @(negedge ap_clk);
        chk("rst_y", y_vec, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_idle", ap_idle, 1);
        chk("rst_done", ap_done, 0);
        #1 ap_rst_n = 1'b1;

        load_identity();
        run_dir(1'b1, 1'b1);
        chk("id_y0", yrow(0), 100);
        chk("id_y1", yrow(1), -200);
        chk("id_y2", yrow(2), 300);
        chk("id_ovf", ovf, 0);

        a_mat = '0; x_vec = '0; set_a(0, 0, 8192); set_x(0, 3);
        run_dir(1'b1, 1'b1); chk("rnd_p3_half_up", yrow(0), 2);
        a_mat = '0; x_vec = '0; set_a(0, 0, 8192); set_x(0, 3);
        run_dir(1'b0, 1'b1); chk("rnd_p3_floor", yrow(0), 1);
        a_mat = '0; x_vec = '0; set_a(0, 0, 8192); set_x(0, -3);
        run_dir(1'b1, 1'b1); chk("rnd_m3_half_up", yrow(0), -1);
        a_mat = '0; x_vec = '0; set_a(0, 0, 8192); set_x(0, -3);
        run_dir(1'b0, 1'b1); chk("rnd_m3_floor", yrow(0), -2);

        for (int k = 0; k < 3; k++) begin
            a_mat = '0;
            for (int c = 0; c < COLS; c++) begin
                set_a(0, c, 1048575);
                set_x(c, (k == 1) ? -1048575 : 1048575);
            end
            run_dir(1'b1, (k == 2) ? 1'b0 : 1'b1);
            case (k)
                0: chk("sat_pos_y0", yrow(0), 1048575);
                1: chk("sat_neg_y0", yrow(0), -1048576);
                default: chk("wrap_y0", yrow(0), -384);
            endcase
            chk("sat_ovf0", ovf[0], 1);
        end

        a_mat = '0; x_vec = '0;
        set_a(1, 0, 16384); set_a(1, 1, 16384); set_a(1, 2, -16384);
        set_x(0, 10); set_x(1, 20); set_x(2, 5);
        run_dir(1'b0, 1'b1);
        chk("acc_y1", yrow(1), 25);
        chk("acc_ovf", ovf, 0);

        // Start pulse while busy must not launch a second run.
        load_identity();
        start_run(1'b1, 1'b1);
        repeat (3) @(negedge ap_clk);
        #1 ap_start = 1'b1;
        @(negedge ap_clk);
        #1 ap_start = 1'b0;
        count_dones(40, cnt);
        chk("busy_start_one_done", cnt, 1);

        // Held start: two accepted runs, spacing enforced by the scoreboard.
        @(negedge ap_clk);
        #1 scramble();
        rnd_mode = 1'b1;
        sat_mode = 1'b0;
        ap_start = 1'b1;
        cnt = n_acc + 2;
        wait_acc(cnt);
        #1 ap_start = 1'b0;
        wait_drained();

        // Reset in the middle of a run aborts it.
        load_identity();
        start_run(1'b1, 1'b1);
        repeat (4) @(posedge ap_clk);
        #1 ap_rst_n = 1'b0;
        @(negedge ap_clk);
        chk("midrst_y", y_vec, 0);
        chk("midrst_idle", ap_idle, 1);
        @(negedge ap_clk);
        chk("midrst_ovf", ovf, 0);
        #1 ap_rst_n = 1'b1;
        count_dones(20, cnt);
        chk("midrst_no_done", cnt, 0);
        load_identity();
        run_dir(1'b0, 1'b1);
        chk("post_rst_y0", yrow(0), 100);
        chk("post_rst_y2", yrow(2), 300);

        for (int i = 0; i < 300; i++) begin
            scramble();
            start_run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        wait_drained();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
